// File: rtl/l2_writeback_buffer_if.sv
// l2_writeback_buffer_if: LLC-side and memory-side bus of the write-back buffer
interface l2_writeback_buffer_if;
   logic [31:0]  llc_address_i;
   logic [255:0] llc_line_i;
   logic         llc_read_i;
   logic         llc_write_i;
   logic [255:0] llc_line_o;
   logic         llc_resp_o;
   logic [255:0] mem_line_i;
   logic         mem_resp_i;
   logic [31:0]  mem_address_o;
   logic [255:0] mem_line_o;
   logic         mem_read_o;
   logic         mem_write_o;
   logic         empty_o;
   modport slave (
      input  llc_address_i, llc_line_i, llc_read_i, llc_write_i, mem_line_i, mem_resp_i,
      output llc_line_o, llc_resp_o, mem_address_o, mem_line_o, mem_read_o, mem_write_o, empty_o
   );
   modport master (
      output llc_address_i, llc_line_i, llc_read_i, llc_write_i, mem_line_i, mem_resp_i,
      input  llc_line_o, llc_resp_o, mem_address_o, mem_line_o, mem_read_o, mem_write_o, empty_o
   );
endinterface

// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: LLC write-back FIFO with coalescing, read forwarding and idle-time draining
module l2_writeback_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   l2_writeback_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, LLC_RESP, MEM_RD, MEM_WR} state_t;
   state_t           state, state_n;
   logic [DEPTH-1:0] valid;
   logic [26:0]      tag_q  [DEPTH];
   logic [255:0]     line_q [DEPTH];
   logic [AW-1:0]    head, tail, hit_idx;
   logic [AW:0]      count;
   logic [26:0]      req_tag;
   logic             hit, full, coalesce, push, pop;
   logic             resp_n, mem_read_n, mem_write_n;
   logic [31:0]      mem_address_n;
   logic [255:0]     mem_line_n, llc_line_n;
   logic             unused_low;
   assign req_tag    = bus.llc_address_i[31:5];
   assign unused_low = ^bus.llc_address_i[4:0];
   assign full       = count == (AW+1)'(DEPTH);
   // find the (at most one) valid entry holding the requested line
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++)
         if (valid[i] && tag_q[i] == req_tag) begin
            hit     = 1'b1;
            hit_idx = AW'(i);
         end
   end
   // next state, next registered outputs and FIFO actions; a write wins over a simultaneous read
   always_comb begin
      state_n       = state;
      resp_n        = 1'b0;
      mem_read_n    = bus.mem_read_o;
      mem_write_n   = bus.mem_write_o;
      mem_address_n = bus.mem_address_o;
      mem_line_n    = bus.mem_line_o;
      llc_line_n    = bus.llc_line_o;
      coalesce      = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      case (state)
         IDLE:
            if (bus.llc_write_i && hit) begin
               coalesce = 1'b1;
               resp_n   = 1'b1;
               state_n  = LLC_RESP;
            end else if (bus.llc_write_i && !full) begin
               push    = 1'b1;
               resp_n  = 1'b1;
               state_n = LLC_RESP;
            end else if (bus.llc_read_i && !bus.llc_write_i && hit) begin
               llc_line_n = line_q[hit_idx];
               resp_n     = 1'b1;
               state_n    = LLC_RESP;
            end else if (bus.llc_read_i && !bus.llc_write_i) begin
               mem_read_n    = 1'b1;
               mem_address_n = {req_tag, 5'b0};
               state_n       = MEM_RD;
            end else if (count != '0) begin
               mem_write_n   = 1'b1;
               mem_address_n = {tag_q[head], 5'b0};
               mem_line_n    = line_q[head];
               state_n       = MEM_WR;
            end
         MEM_RD:
            if (bus.mem_resp_i) begin
               mem_read_n = 1'b0;
               llc_line_n = bus.mem_line_i;
               resp_n     = 1'b1;
               state_n    = LLC_RESP;
            end
         MEM_WR:
            if (bus.mem_resp_i) begin
               mem_write_n = 1'b0;
               pop         = 1'b1;
               state_n     = IDLE;
            end
         LLC_RESP: state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_n;
   // FIFO storage, pointers and registered outputs; buffered lines are dropped on reset
   always_ff @(posedge clk)
      if (rst) begin
         valid             <= '0;
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         bus.llc_resp_o    <= 1'b0;
         bus.llc_line_o    <= '0;
         bus.mem_read_o    <= 1'b0;
         bus.mem_write_o   <= 1'b0;
         bus.mem_address_o <= '0;
         bus.mem_line_o    <= '0;
         bus.empty_o       <= 1'b1;
      end else begin
         if (coalesce) line_q[hit_idx] <= bus.llc_line_i;
         if (push) begin
            valid[tail]  <= 1'b1;
            tag_q[tail]  <= req_tag;
            line_q[tail] <= bus.llc_line_i;
            tail         <= tail + AW'(1);
         end
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + AW'(1);
         end
         count             <= count + (AW+1)'(push) - (AW+1)'(pop);
         bus.llc_resp_o    <= resp_n;
         bus.llc_line_o    <= llc_line_n;
         bus.mem_read_o    <= mem_read_n;
         bus.mem_write_o   <= mem_write_n;
         bus.mem_address_o <= mem_address_n;
         bus.mem_line_o    <= mem_line_n;
         bus.empty_o       <= count == '0 && state == IDLE;
      end
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: randomized bench checked against a queue-of-lines buffer model and a memory map
module tb_l2_writeback_buffer;
   typedef struct {logic [26:0] tag; logic [255:0] line;} ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   l2_writeback_buffer_if b();
   l2_writeback_buffer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(b.slave));
   always #5 clk = ~clk;

   ent_t         q[$];
   logic [255:0] mem_model [logic [26:0]];
   int           n_vec = 0, n_miss = 0, cyc = 0, done_cyc = 0, resp_cyc = 0;
   int           n_rd = 0, n_wr = 0, lat = 0, fixed_lat = -1;
   bit           busy = 1'b0, req_wr = 1'b0;
   logic [31:0]  rec_addr = '0, last_wr_addr = '0;
   logic [255:0] rec_line = '0, last_wr_line = '0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic int find(input logic [26:0] t);
      for (int i = 0; i < q.size(); i++)
         if (q[i].tag == t) return i;
      return -1;
   endfunction

   function automatic logic [255:0] mem_val(input logic [26:0] t);
      return mem_model.exists(t) ? mem_model[t] : {8{{5'b0, t} ^ 32'h5a5a_0f0f}};
   endfunction

   function automatic logic [255:0] rnd_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // one clock: sample just after the edge, then play the memory side
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (b.mem_resp_i) begin
         b.mem_resp_i = 1'b0;
         busy         = 1'b0;
         done_cyc     = cyc;
         check("mem_req_drop", {b.mem_read_o, b.mem_write_o}, 2'b00);
         if (req_wr) begin
            mem_model[rec_addr[31:5]] = rec_line;
            if (q.size() != 0) void'(q.pop_front());
            n_wr++;
         end
      end else if (busy) begin
         check("mem_addr_hold", b.mem_address_o, rec_addr);
         check("mem_req_hold", req_wr ? b.mem_write_o : b.mem_read_o, 1'b1);
         if (req_wr) check("mem_line_hold", b.mem_line_o, rec_line);
      end else if (b.mem_read_o || b.mem_write_o) begin
         busy     = 1'b1;
         req_wr   = b.mem_write_o;
         rec_addr = b.mem_address_o;
         rec_line = b.mem_line_o;
         lat      = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 4));
         check("mem_rw_exclusive", b.mem_read_o & b.mem_write_o, 1'b0);
         check("mem_addr_aligned", rec_addr[4:0], 5'd0);
         if (req_wr) begin
            last_wr_addr = rec_addr;
            last_wr_line = rec_line;
            check("drain_nonempty", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
               check("drain_addr_oldest", rec_addr, {q[0].tag, 5'b0});
               check("drain_line_oldest", rec_line, q[0].line);
            end
         end else begin
            n_rd++;
            check("rd_no_overtake", find(rec_addr[31:5]) >= 0, 1'b0);
         end
      end
      if (busy && !b.mem_resp_i) begin
         if (lat == 0) begin
            b.mem_resp_i = 1'b1;
            b.mem_line_i = req_wr ? rnd_line() : mem_val(rec_addr[31:5]);
         end else lat--;
      end
   endtask

   // present one LLC request, wait for its response, update the model, step past LLC_RESP
   task automatic llc_req(input bit w, input logic [31:0] a, input logic [255:0] d, output int n);
      int k;
      ent_t e;
      b.llc_write_i   = w;
      b.llc_read_i    = !w;
      b.llc_address_i = a;
      b.llc_line_i    = d;
      n = 0;
      do begin
         tick();
         n++;
      end while (!b.llc_resp_o && n < 300);
      check("llc_resp_seen", b.llc_resp_o, 1'b1);
      resp_cyc = cyc;
      if (b.llc_resp_o) begin
         k = find(a[31:5]);
         if (w) begin
            if (k >= 0) q[k].line = d;
            else begin
               e.tag  = a[31:5];
               e.line = d;
               q.push_back(e);
            end
            check("occupancy_le_depth", q.size() <= 4, 1'b1);
         end else
            check("llc_read_data", b.llc_line_o, k >= 0 ? q[k].line : mem_val(a[31:5]));
      end
      b.llc_write_i = 1'b0;
      b.llc_read_i  = 1'b0;
      tick();
      check("llc_resp_one_cycle", b.llc_resp_o, 1'b0);
   endtask

   task automatic drain_all();
      int k = 0;
      while (!(q.size() == 0 && !busy && b.empty_o) && k < 300) begin
         tick();
         k++;
      end
      check("drained_empty_o", b.empty_o, 1'b1);
      check("drained_model_empty", q.size(), 0);
   endtask

   initial begin
      int n, r0, w0, k;
      logic [31:0] a;
      logic [255:0] da, dx, dy1, dy2, dz, db;
      b.llc_address_i = '0;
      b.llc_line_i    = '0;
      b.llc_read_i    = 1'b0;
      b.llc_write_i   = 1'b0;
      b.mem_line_i    = '0;
      b.mem_resp_i    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_llc_resp", b.llc_resp_o, 1'b0);
      check("rst_llc_line", b.llc_line_o, '0);
      check("rst_mem_read", b.mem_read_o, 1'b0);
      check("rst_mem_write", b.mem_write_o, 1'b0);
      check("rst_mem_addr", b.mem_address_o, '0);
      check("rst_mem_line", b.mem_line_o, '0);
      check("rst_empty", b.empty_o, 1'b1);
      rst = 1'b0;
      tick();
      tick();
      check("idle_quiet", {b.mem_read_o, b.mem_write_o, b.llc_resp_o}, 3'b000);
      check("idle_empty", b.empty_o, 1'b1);
      // single write, then idle drain
      da = rnd_line();
      llc_req(1'b1, 32'h1000, da, n);
      check("wr_latency", n, 1);
      drain_all();
      check("a_drain_addr", last_wr_addr, 32'h1000);
      check("a_drain_line", last_wr_line, da);
      // read hit served from the buffer
      dx = rnd_line();
      llc_req(1'b1, 32'h2000, dx, n);
      r0 = n_rd;
      llc_req(1'b0, 32'h2004, '0, n);
      check("hit_latency", n, 1);
      check("hit_data", b.llc_line_o, dx);
      check("hit_no_mem_read", n_rd - r0, 0);
      drain_all();
      // coalescing
      dy1 = rnd_line();
      dy2 = rnd_line();
      w0 = n_wr;
      llc_req(1'b1, 32'h3000, dy1, n);
      llc_req(1'b1, 32'h3000, dy2, n);
      check("coalesce_latency", n, 1);
      drain_all();
      check("coalesce_one_drain", n_wr - w0, 1);
      check("coalesce_drain_addr", last_wr_addr, 32'h3000);
      check("coalesce_drain_line", last_wr_line, dy2);
      // fill, then write to a full buffer
      for (int i = 1; i <= 4; i++) begin
         llc_req(1'b1, 32'(i * 32'h100), rnd_line(), n);
         check("fill_latency", n, 1);
      end
      w0 = n_wr;
      llc_req(1'b1, 32'h500, rnd_line(), n);
      check("full_one_drain", n_wr - w0, 1);
      check("full_drain_oldest", last_wr_addr, 32'h100);
      check("full_resp_gap", resp_cyc - done_cyc, 1);
      // read miss with a fixed 6-cycle memory latency
      dz = rnd_line();
      mem_model[27'h400] = dz;
      fixed_lat = 6;
      r0 = n_rd;
      llc_req(1'b0, 32'h8000, '0, n);
      fixed_lat = -1;
      check("miss_one_mem_read", n_rd - r0, 1);
      check("miss_data", b.llc_line_o, dz);
      check("miss_resp_after_mem", resp_cyc, done_cyc);
      check("miss_latency", n, 8);
      db = q[0].line;
      r0 = n_rd;
      llc_req(1'b0, 32'h204, '0, n);
      check("untouched_hit_latency", n, 1);
      check("untouched_hit_data", b.llc_line_o, db);
      check("untouched_no_mem_read", n_rd - r0, 0);
      // reset in the middle of a drain with three entries left
      w0 = n_wr;
      k = 0;
      while (n_wr == w0 && k < 200) begin
         tick();
         k++;
      end
      fixed_lat = 40;
      k = 0;
      while (!(busy && req_wr) && k < 200) begin
         tick();
         k++;
      end
      check("second_drain_started", busy && req_wr, 1'b1);
      check("entries_during_drain", q.size(), 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_mem_write", b.mem_write_o, 1'b0);
      check("midrst_empty", b.empty_o, 1'b1);
      rst          = 1'b0;
      busy         = 1'b0;
      b.mem_resp_i = 1'b0;
      fixed_lat    = -1;
      q.delete();
      r0 = n_rd;
      llc_req(1'b0, 32'h500, '0, n);
      check("post_rst_miss", n_rd - r0, 1);
      check("post_rst_data", b.llc_line_o, {8{{5'b0, 27'h28} ^ 32'h5a5a_0f0f}});
      // random traffic over a small pool of lines
      for (int i = 0; i < 300; i++) begin
         a = 32'h800 + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
         llc_req(1'($urandom_range(0, 1)), a, rnd_line(), n);
         repeat ($urandom_range(0, 5)) tick();
      end
      drain_all();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/l2_writeback_buffer.md
# l2_writeback_buffer

Write-back buffer between the last-level cache and the cacheline adaptor. Absorbs dirty-line evictions from the LLC into a small FIFO and acknowledges them in one cycle. Drains the FIFO to memory when the LLC is idle. Serves LLC read misses either from the buffer (on a line-address match) or from memory, so a read never overtakes a pending write to the same line.

## Interface
- DEPTH, 4, number of 256-bit entries; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- llc_address_i  in  32  LLC request byte address; bits [4:0] ignored
- llc_line_i  in  256  write data from LLC
- llc_read_i  in  1  LLC read request; held until llc_resp_o
- llc_write_i  in  1  LLC write-back request; held until llc_resp_o
- llc_line_o  out  256  read data to LLC; valid while llc_resp_o=1
- llc_resp_o  out  1  one-cycle completion pulse to LLC
- mem_line_i  in  256  read line from adaptor
- mem_resp_i  in  1  adaptor completion pulse
- mem_address_o  out  32  line-aligned address to adaptor; bits [4:0]=0
- mem_line_o  out  256  write line to adaptor (FIFO head)
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- empty_o  out  1  1 when no valid entries and FSM in IDLE

## Operation
- Each entry holds a valid bit, tag = address[31:5], and a 256-bit line. Circular FIFO: head (oldest), tail, count 0..DEPTH. Pointers wrap mod DEPTH.
- FSM states: IDLE, LLC_RESP, MEM_RD, MEM_WR. All outputs are registered.
- IDLE priority order, evaluated each cycle:
  - 1. llc_write_i with tag match to a valid entry: overwrite that entry's line in place (coalesce). Count unchanged. Go to LLC_RESP.
  - 2. llc_write_i, no match, count<DEPTH: write at tail, tail++, count++. Go to LLC_RESP.
  - 3. llc_read_i with tag match: latch the entry line into llc_line_o. Go to LLC_RESP.
  - 4. llc_read_i, no match: go to MEM_RD with mem_address_o={tag,5'b0}.
  - 5. llc_write_i, no match, count==DEPTH: go to MEM_WR to drain the head (the write stalls).
  - 6. No request and count>0: go to MEM_WR with mem_address_o={head tag,5'b0} and mem_line_o=head line.
- MEM_RD: mem_read_o=1 until mem_resp_i. On mem_resp_i, latch mem_line_i into llc_line_o and go to LLC_RESP.
- MEM_WR: mem_write_o=1 until mem_resp_i. On mem_resp_i, clear head valid, head++, count-- and go to IDLE. A drain is never preempted by a new LLC request.
- LLC_RESP: llc_resp_o=1 for exactly this cycle. LLC requests are ignored in this cycle because the LLC still holds them. Next state is IDLE.
- Simultaneous llc_read_i and llc_write_i: protocol violation; write is served first.
- Reset (any state, including mid-drain): all valid bits, head, tail and count cleared; buffered lines are discarded; state IDLE. Reset values of all outputs are 0, except empty_o=1.

## Timing
- Write accepted (not full) or read hit, request first sampled in IDLE at cycle N: llc_resp_o=1 at N+1, request ignored at N+1, IDLE at N+2.
- Read miss sampled at N: mem_read_o=1 from N+1. If mem_resp_i arrives at M: mem_read_o=0 and llc_resp_o=1 with data at M+1.
- Drain decided at N: mem_write_o=1 from N+1 through the cycle mem_resp_i is seen (M). At M+1, mem_write_o=0, count has decremented, and the FSM is in IDLE.
- Write to a full buffer completes at earliest: drain M, accept at M+1, llc_resp_o at M+2.
- mem_address_o and mem_line_o are stable for the whole duration of each memory request.
- empty_o updates the cycle after the count or FSM state changes.

## Test plan
- Reset, then idle: all outputs 0 and empty_o=1. Write line A (address 0x1000) -> llc_resp_o at N+1. With the LLC idle, a drain starts: mem_write_o=1 with mem_address_o=0x1000 and data A, until mem_resp_i; empty_o=1 afterwards.
- Write 0x2000=X, then read 0x2004 before the drain starts -> read hit, llc_line_o=X, no mem_read_o asserted.
- Write 0x3000=Y1, then 0x3000=Y2 -> count stays 1; the later drain writes Y2 only.
- Fill 4 entries (0x100, 0x200, 0x300, 0x400), then write 0x500 -> the 0x100 entry drains first, and llc_resp_o for 0x500 arrives 2 cycles after that drain's mem_resp_i.
- Read miss 0x8000 with mem_resp_i after 6 cycles and mem_line_i=Z -> llc_resp_o=1 with llc_line_o=Z on the next cycle; the buffered entries are untouched.
- Assert rst during MEM_WR with 3 entries -> next cycle: mem_write_o=0, empty_o=1, and a subsequent read of a previously buffered address misses to memory.
